// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types for the prefetch fetch unit
package fetch_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - prefetch queue: circular buffer with wrap-bit pointers, flush, push/pop
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       flush,
  input  logic                       push,
  input  logic [W-1:0]               wdata,
  input  logic                       pop,
  output logic [W-1:0]               rdata,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW   = $clog2(DEPTH);
  localparam int PTRW = PW + 1;
  localparam int CW   = $clog2(DEPTH + 1);

  logic [PTRW-1:0] wr_ptr, rd_ptr;
  logic [W-1:0]    mem [DEPTH];
  logic            full, do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  // flush takes priority over any push or pop presented in the same cycle
  assign do_push = push & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign count   = CW'(wr_ptr - rd_ptr);
  assign rdata   = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge CLK) begin
    if (!RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTRW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTRW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST && do_push) mem[wr_ptr[PW-1:0]] <= wdata;
  end

  always_ff @(posedge CLK) begin
    if (RST) assert (!(do_push && full && !do_pop));
  end

endmodule

// File: rtl/prefetch_fetch_unit.sv
// rtl/prefetch_fetch_unit.sv - instruction fetch stage with prefetch queue and redirect
module prefetch_fetch_unit
  import fetch_pkg::*;
#(
  parameter int             AW     = 8,
  parameter int             DW     = 8,
  parameter int             DEPTH  = 4,
  parameter logic [AW-1:0]  RST_PC = '0
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       fetch_en,
  input  logic                       redirect_valid,
  input  logic [AW-1:0]              redirect_pc,
  output logic                       mem_rd,
  output logic [AW-1:0]              mem_addr,
  input  logic [DW-1:0]              mem_rdata,
  output logic                       instr_valid,
  input  logic                       instr_ready,
  output logic [DW-1:0]              instr_data,
  output logic [AW-1:0]              instr_pc,
  output logic [$clog2(DEPTH+1)-1:0] q_count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = CW + 1;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [DW-1:0] data;
  } fetch_entry_t;

  fetch_state_t  state, state_nxt;
  logic [AW-1:0] pc, tag;
  logic          inflight, pop, push, issue, empty;
  logic [OW-1:0] occ;
  fetch_entry_t  wr_e, rd_e;

  assign inflight = (state == REQ);
  assign pop      = instr_valid & instr_ready;
  // slots already promised: queued words plus the one landing this cycle, minus the one leaving
  assign occ      = {1'b0, q_count} + OW'(inflight) - OW'(pop);
  assign issue    = RST & fetch_en & ~redirect_valid & (occ < OW'(DEPTH));
  // a response arriving in a redirect cycle belongs to the old stream and is dropped
  assign push     = inflight & ~redirect_valid;

  always_comb begin
    state_nxt = IDLE;
    mem_rd    = 1'b0;
    mem_addr  = pc;
    if (issue) begin
      state_nxt = REQ;
      mem_rd    = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state <= IDLE;
      pc    <= RST_PC;
      tag   <= '0;
    end else begin
      state <= state_nxt;
      if (redirect_valid) pc <= redirect_pc;
      else if (issue)     pc <= pc + AW'(1);
      if (issue) tag <= pc;
    end
  end

  assign wr_e.pc   = tag;
  assign wr_e.data = mem_rdata;

  fetch_fifo #(
    .DEPTH(DEPTH),
    .W    ($bits(fetch_entry_t))
  ) u_fifo (
    .CLK  (CLK),
    .RST  (RST),
    .flush(redirect_valid),
    .push (push),
    .wdata(wr_e),
    .pop  (pop),
    .rdata(rd_e),
    .empty(empty),
    .count(q_count)
  );

  assign instr_valid = ~empty;
  assign instr_data  = rd_e.data;
  assign instr_pc    = rd_e.pc;

endmodule
